// File: rtl/avalon_bus_matrix_arbiter_rr.sv
// Slave-port arbiter for the Avalon bus matrix: fixed-priority or round-robin
// selection of NUM_PORTS masters, grant held for the whole transfer.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   Req_i        - per-master level request, bit n = master n
//   Done_i       - one-cycle end-of-transfer pulse from the slave side
//   Grant_o      - registered one-hot grant, zero when idle
//   PortSel_o    - registered binary index of the granted master, 0 when idle
//   PortNoSel_o  - registered "no master granted" flag (= ~|Grant_o)

module avalon_bus_matrix_arbiter_rr #(
  parameter int NUM_PORTS = 5,
  parameter int SEL_W     = 3,
  parameter int RR_MODE   = 1,
  parameter int MAX_HOLD  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] Req_i,
  input  logic                 Done_i,
  output logic [NUM_PORTS-1:0] Grant_o,
  output logic [SEL_W-1:0]     PortSel_o,
  output logic                 PortNoSel_o
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_GRANTED = 1'b1;

  // Counter only needs to reach MAX_HOLD-1, where it saturates.
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_L = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_L);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  logic [0:0]           state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [SEL_W-1:0]     sel_q;
  logic                 nosel_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [SEL_W-1:0]     last_q;

  logic                 owner_req;
  logic                 others_req;
  logic                 timeout;
  logic                 rel;
  logic                 arb;
  logic                 any_req;
  logic [SEL_W-1:0]     win_idx;
  logic [NUM_PORTS-1:0] win_oh;

  // Release / arbitration enables.
  always_comb begin
    owner_req  = |(Req_i & grant_q);
    others_req = |(Req_i & ~grant_q);
    any_req    = |Req_i;
    // A saturated counter with nobody else waiting keeps the grant.
    timeout    = HOLD_EN && (hold_q == HOLD_LAST) && others_req;
    rel        = (state_q == ST_GRANTED) &&
                 (Done_i || !owner_req || timeout);
    arb        = (state_q == ST_IDLE) || rel;
  end

  // Winner selection.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    win_idx = '0;
    if (RR_MODE != 0) begin
      // Search last+1 .. last+NUM_PORTS, wrapping; the released port is
      // therefore visited last.
      for (int k = 1; k <= NUM_PORTS; k++) begin
        idx = int'(last_q) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!found && Req_i[idx]) begin
          found   = 1'b1;
          win_idx = SEL_W'(idx);
        end
      end
    end else begin
      // Scan downward so the lowest asserted index is written last.
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (Req_i[k]) win_idx = SEL_W'(k);
      end
    end
    win_oh = NUM_PORTS'(1) << win_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      nosel_q <= 1'b1;
      hold_q  <= '0;
      last_q  <= SEL_W'(NUM_PORTS - 1);
    end else if (arb) begin
      if (any_req) begin
        state_q <= ST_GRANTED;
        grant_q <= win_oh;
        sel_q   <= win_idx;
        nosel_q <= 1'b0;
        hold_q  <= '0;
        last_q  <= win_idx;
      end else begin
        state_q <= ST_IDLE;
        grant_q <= '0;
        sel_q   <= '0;
        nosel_q <= 1'b1;
        hold_q  <= '0;
      end
    end else if (hold_q != HOLD_LAST) begin
      hold_q <= hold_q + HOLD_W'(1);
    end
  end

  assign Grant_o     = grant_q;
  assign PortSel_o   = sel_q;
  assign PortNoSel_o = nosel_q;

endmodule

// File: tb/tb_avalon_bus_matrix_arbiter_rr.sv
// Bench for avalon_bus_matrix_arbiter_rr: four configurations checked
// every cycle against a transfer-level reference model.

module tb_avalon_bus_matrix_arbiter_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] rq [4];
  logic [3:0]  dn;

  logic [4:0]  g0, g1;
  logic [1:0]  g2;
  logic [15:0] g3;
  logic [2:0]  s0, s1;
  logic [0:0]  s2;
  logic [3:0]  s3;
  logic        n0, n1, n2, n3;

  avalon_bus_matrix_arbiter_rr #(
    .NUM_PORTS(5), .SEL_W(3), .RR_MODE(1), .MAX_HOLD(4)
  ) u_rr (
    .clk(clk), .rst(rst), .Req_i(rq[0][4:0]), .Done_i(dn[0]),
    .Grant_o(g0), .PortSel_o(s0), .PortNoSel_o(n0)
  );

  avalon_bus_matrix_arbiter_rr #(
    .NUM_PORTS(5), .SEL_W(3), .RR_MODE(0), .MAX_HOLD(16)
  ) u_fp (
    .clk(clk), .rst(rst), .Req_i(rq[1][4:0]), .Done_i(dn[1]),
    .Grant_o(g1), .PortSel_o(s1), .PortNoSel_o(n1)
  );

  avalon_bus_matrix_arbiter_rr #(
    .NUM_PORTS(2), .SEL_W(1), .RR_MODE(1), .MAX_HOLD(4)
  ) u_w2 (
    .clk(clk), .rst(rst), .Req_i(rq[2][1:0]), .Done_i(dn[2]),
    .Grant_o(g2), .PortSel_o(s2), .PortNoSel_o(n2)
  );

  avalon_bus_matrix_arbiter_rr #(
    .NUM_PORTS(16), .SEL_W(4), .RR_MODE(1), .MAX_HOLD(4)
  ) u_w16 (
    .clk(clk), .rst(rst), .Req_i(rq[3]), .Done_i(dn[3]),
    .Grant_o(g3), .PortSel_o(s3), .PortNoSel_o(n3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: current owner (-1 = none), cycles granted so far, last winner.
  int m_cur  [4];
  int m_len  [4];
  int m_last [4];
  int wait_c [4][16];

  function automatic int pn(int i);
    case (i)
      0, 1:    return 5;
      2:       return 2;
      default: return 16;
    endcase
  endfunction

  function automatic int prr(int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int pmh(int i);
    return (i == 1) ? 16 : 4;
  endfunction

  function automatic logic [31:0] gnt(int i);
    case (i)
      0:       return 32'(g0);
      1:       return 32'(g1);
      2:       return 32'(g2);
      default: return 32'(g3);
    endcase
  endfunction

  function automatic logic [31:0] sel(int i);
    case (i)
      0:       return 32'(s0);
      1:       return 32'(s1);
      2:       return 32'(s2);
      default: return 32'(s3);
    endcase
  endfunction

  function automatic logic [31:0] nsel(int i);
    case (i)
      0:       return 32'(n0);
      1:       return 32'(n1);
      2:       return 32'(n2);
      default: return 32'(n3);
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(int act, int n, int rr, int last);
    if (act == 0) return -1;
    if (rr == 0) begin
      for (int p = 0; p < n; p++) if (act[p]) return p;
    end else begin
      for (int k = 1; k <= n; k++) if (act[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cur[i]  = -1;
      m_len[i]  = 0;
      m_last[i] = pn(i) - 1;
      for (int p = 0; p < 16; p++) wait_c[i][p] = 0;
    end
  endtask

  task automatic model_step(int i);
    int act, w, c;
    bit rel, others;
    act = int'(rq[i]) & ((1 << pn(i)) - 1);
    c   = m_cur[i];
    if (c >= 0) begin
      others = (act & ~(1 << c)) != 0;
      rel = dn[i] || !act[c] ||
            (pmh(i) != 0 && m_len[i] >= pmh(i) && others);
    end else begin
      rel = 1'b1;
    end
    if (rel) begin
      w = pick(act, pn(i), prr(i), m_last[i]);
      m_cur[i] = w;
      m_len[i] = (w < 0) ? 0 : 1;
      if (w >= 0) m_last[i] = w;
    end else begin
      m_len[i]++;
    end
  endtask

  task automatic compare(int i);
    logic [31:0] eg, g;
    int bound;
    eg = (m_cur[i] >= 0) ? (32'd1 << m_cur[i]) : 32'd0;
    chk($sformatf("u%0d.grant", i), gnt(i), eg);
    chk($sformatf("u%0d.sel", i), sel(i), (m_cur[i] >= 0) ? m_cur[i] : 0);
    chk($sformatf("u%0d.nosel", i), nsel(i), 32'(m_cur[i] < 0));
    if (prr(i) != 0) begin
      g = gnt(i);
      bound = pn(i) * pmh(i) + 2;
      for (int p = 0; p < pn(i); p++) begin
        if (rq[i][p] && !g[p]) begin
          wait_c[i][p]++;
        end else begin
          if (wait_c[i][p] > 0)
            chk($sformatf("u%0d.starve%0d", i, p),
                32'(wait_c[i][p] <= bound), 32'd1);
          wait_c[i][p] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 4; i++) compare(i);
  endtask

  initial begin
    rst = 1'b1;
    dn  = '0;
    for (int i = 0; i < 4; i++) rq[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) compare(i);
    rst = 1'b0;

    // Fixed priority: lowest index, re-grant after done.
    rq[1] = 16'b10110;
    step();
    chk("fp.sel", sel(1), 1);
    chk("fp.grant", gnt(1), 32'b00010);
    dn[1] = 1'b1;
    step();
    dn[1] = 1'b0;
    chk("fp.regrant", sel(1), 1);
    chk("fp.noidle", nsel(1), 0);
    rq[1] = '0;
    step();

    // Round-robin rotation, done every 3rd cycle.
    rq[0] = 16'b11111;
    step();
    for (int g = 0; g < 6; g++) begin
      for (int c = 0; c < 3; c++) begin
        chk("rr.seq", sel(0), g % 5);
        chk("rr.busy", nsel(0), 0);
        dn[0] = (c == 2);
        step();
        dn[0] = 1'b0;
      end
    end
    rq[0] = '0;
    step();

    // Hold timeout: port 3 holds 4 cycles, 4 skipped, 1 wins.
    rq[0] = 16'b01000;
    step();
    rq[0] = 16'b01010;
    for (int c = 0; c < 4; c++) begin
      chk("hold.owner", sel(0), 3);
      step();
    end
    chk("hold.next", sel(0), 1);
    rq[0] = '0;
    step();
    rq[0] = 16'b01000;
    step();
    for (int c = 0; c < 24; c++) begin
      chk("hold.alone", sel(0), 3);
      step();
    end
    rq[0] = '0;
    step();

    // Abandon, then done in idle.
    rq[0] = 16'b00100;
    step();
    chk("abn.grant", sel(0), 2);
    rq[0] = '0;
    step();
    chk("abn.idle", nsel(0), 1);
    dn[0] = 1'b1;
    step();
    dn[0] = 1'b0;
    chk("spur.idle", nsel(0), 1);
    chk("spur.grant", gnt(0), 0);

    // Asynchronous reset mid-grant of port 2.
    rq[0] = 16'b00100;
    step();
    chk("rst.pre", sel(0), 2);
    rst   = 1'b1;
    rq[0] = '0;
    #1;
    model_reset();
    chk("rst.grant", gnt(0), 0);
    chk("rst.sel", sel(0), 0);
    chk("rst.nosel", nsel(0), 1);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) compare(i);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rst.quiet", nsel(0), 1);
    end

    // Random traffic on every configuration.
    for (int cyc = 0; cyc < 5000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        for (int p = 0; p < pn(i); p++)
          if ($urandom_range(0, 7) == 0) rq[i][p] = ~rq[i][p];
        dn[i] = ($urandom_range(0, 5) == 0);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
